i2c_loopback_top: RTL and testbench

- Self-contained I2C subsystem: a single-byte I2C master and a single-register I2C slave share open-drain SDA/SCL lines.
- The host issues one write or read transaction per `enable` request.
- The master generates START, a 7-bit address plus R/W bit, one data byte, ACK/NACK handling and STOP.
- Used as a bus-level integration block and for protocol bring-up.

---
 rtl/i2c_loopback_top.sv | 325 ++++++++++++++++++++++++++++++++
 tb/tb_i2c_loopback_top.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_loopback_top.sv
// i2c_loopback_top: single-byte I2C master and single-register I2C slave
// sharing one pair of open-drain lines.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous reset, active-low
//   addr      7-bit target address for the next transaction
//   data_in   byte sent on a write transaction
//   enable    level-sampled request; accepted in IDLE while ready=1
//   rw        0 = write, 1 = read
//   data_out  byte received by the last acknowledged read
//   ready     master idle and able to accept a request
//   i2c_sda   open-drain data line (driven 0 or released)
//   i2c_scl   open-drain clock line (driven 0 or released)
//
// Bit timing, in system clocks from the falling edge of SCL (H = SCL_HALF):
//   cnt 0        SCL low
//   cnt H/2      master updates SDA (the slave updates 1 clk after SCL falls)
//   cnt H        SCL released high; the slave samples 1 clk later
//   cnt 2H-1     master samples SDA and moves to the next bit
module i2c_loopback_top #(
    parameter logic [6:0] SLAVE_ADDR = 7'h2A,
    parameter int         SCL_HALF   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] addr,
    input  logic [7:0] data_in,
    input  logic       enable,
    input  logic       rw,
    output logic [7:0] data_out,
    output logic       ready,
    inout  wire        i2c_sda,
    inout  wire        i2c_scl
);

    localparam int            CW   = $clog2(2 * SCL_HALF);
    localparam logic [CW-1:0] HALF = CW'(SCL_HALF);
    localparam logic [CW-1:0] QTR  = CW'(SCL_HALF / 2);
    localparam logic [CW-1:0] LAST = CW'(2 * SCL_HALF - 1);

    typedef enum logic [3:0] {
        M_IDLE, M_START, M_ADDR, M_ADDR_ACK, M_WR_DATA,
        M_WR_ACK, M_RD_DATA, M_RD_NACK, M_STOP
    } m_state_t;

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_WR, S_WR_ACK, S_RD
    } s_state_t;

    // Master state
    m_state_t      m_state_q, m_state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    rx_q, rx_d;
    logic [6:0]    addr_q, addr_d;
    logic [7:0]    data_q, data_d;
    logic          rw_q, rw_d;
    logic          m_scl_low_q, m_scl_low_d;
    logic          m_sda_low_q, m_sda_low_d;
    logic          ready_q, ready_d;
    logic [7:0]    data_out_q, data_out_d;

    // Slave state
    s_state_t      s_state_q, s_state_d;
    logic [3:0]    s_cnt_q, s_cnt_d;
    logic [7:0]    s_shift_q, s_shift_d;
    logic [7:0]    s_reg_q, s_reg_d;
    logic          s_rw_q, s_rw_d;
    logic          s_sda_low_q, s_sda_low_d;
    logic          scl_prev_q, scl_prev_d;
    logic          sda_prev_q, sda_prev_d;

    // Every driver of both lines lives in this block, so the resolved wired-AND
    // level is computed directly instead of reading back through the pads.
    logic scl_line, sda_line;
    assign scl_line = ~m_scl_low_q;
    assign sda_line = ~(m_sda_low_q | s_sda_low_q);
    assign i2c_scl  = m_scl_low_q ? 1'b0 : 1'bz;
    assign i2c_sda  = (m_sda_low_q | s_sda_low_q) ? 1'b0 : 1'bz;

    assign ready    = ready_q;
    assign data_out = data_out_q;

    // ---------------------------------------------------------------- master
    logic [CW-1:0] cnt_nxt;
    logic          bit_end;

    always_comb begin
        m_state_d   = m_state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        rx_d        = rx_q;
        addr_d      = addr_q;
        data_d      = data_q;
        rw_d        = rw_q;
        m_scl_low_d = m_scl_low_q;
        m_sda_low_d = m_sda_low_q;
        ready_d     = ready_q;
        data_out_d  = data_out_q;
        cnt_nxt     = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        bit_end     = (cnt_q == LAST);

        case (m_state_q)
            M_IDLE: begin
                m_scl_low_d = 1'b0;
                m_sda_low_d = 1'b0;
                cnt_d       = '0;
                if (ready_q && enable) begin
                    addr_d    = addr;
                    data_d    = data_in;
                    rw_d      = rw;
                    ready_d   = 1'b0;
                    m_state_d = M_START;
                end else begin
                    ready_d = scl_line & sda_line;
                end
            end
            M_START: begin
                // SCL stays high for the whole slot; SDA falls halfway through.
                cnt_d = cnt_nxt;
                if (cnt_nxt == HALF) m_sda_low_d = 1'b1;
                if (bit_end) begin
                    m_state_d   = M_ADDR;
                    m_scl_low_d = 1'b1;
                    bit_d       = 3'd7;
                    shift_d     = {addr_q, rw_q};
                end
            end
            M_STOP: begin
                // SDA is pulled low while SCL is low, then released after SCL rises.
                cnt_d       = cnt_nxt;
                m_scl_low_d = (cnt_nxt < HALF);
                if (cnt_nxt == QTR)  m_sda_low_d = 1'b1;
                if (cnt_nxt == LAST) m_sda_low_d = 1'b0;
                if (bit_end) begin
                    m_state_d   = M_IDLE;
                    m_scl_low_d = 1'b0;
                end
            end
            default: begin
                // All nine-clock byte/ack slots share one timing skeleton.
                cnt_d       = cnt_nxt;
                m_scl_low_d = (cnt_nxt < HALF);
                if (cnt_nxt == QTR) begin
                    m_sda_low_d = ((m_state_q == M_ADDR) || (m_state_q == M_WR_DATA))
                                  ? ~shift_q[7] : 1'b0;
                end
                if (bit_end) begin
                    case (m_state_q)
                        M_ADDR, M_WR_DATA: begin
                            shift_d = {shift_q[6:0], 1'b0};
                            bit_d   = bit_q - 1'b1;
                            if (bit_q == 3'd0) begin
                                m_state_d = (m_state_q == M_ADDR) ? M_ADDR_ACK : M_WR_ACK;
                            end
                        end
                        M_ADDR_ACK: begin
                            bit_d = 3'd7;
                            if (sda_line) begin
                                m_state_d = M_STOP;
                            end else if (rw_q) begin
                                m_state_d = M_RD_DATA;
                            end else begin
                                m_state_d = M_WR_DATA;
                                shift_d   = data_q;
                            end
                        end
                        M_RD_DATA: begin
                            rx_d  = {rx_q[6:0], sda_line};
                            bit_d = bit_q - 1'b1;
                            if (bit_q == 3'd0) begin
                                m_state_d  = M_RD_NACK;
                                data_out_d = {rx_q[6:0], sda_line};
                            end
                        end
                        default: m_state_d = M_STOP;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_state_q   <= M_IDLE;
            cnt_q       <= '0;
            bit_q       <= 3'd0;
            shift_q     <= 8'h00;
            rx_q        <= 8'h00;
            addr_q      <= 7'h00;
            data_q      <= 8'h00;
            rw_q        <= 1'b0;
            m_scl_low_q <= 1'b0;
            m_sda_low_q <= 1'b0;
            ready_q     <= 1'b0;
            data_out_q  <= 8'h00;
        end else begin
            m_state_q   <= m_state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            rx_q        <= rx_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            rw_q        <= rw_d;
            m_scl_low_q <= m_scl_low_d;
            m_sda_low_q <= m_sda_low_d;
            ready_q     <= ready_d;
            data_out_q  <= data_out_d;
        end
    end

    // ----------------------------------------------------------------- slave
    logic scl_rise, scl_fall, start_c, stop_c;
    assign scl_rise = scl_line & ~scl_prev_q;
    assign scl_fall = ~scl_line & scl_prev_q;
    assign start_c  = scl_line & scl_prev_q & sda_prev_q & ~sda_line;
    assign stop_c   = scl_line & scl_prev_q & ~sda_prev_q & sda_line;

    always_comb begin
        s_state_d   = s_state_q;
        s_cnt_d     = s_cnt_q;
        s_shift_d   = s_shift_q;
        s_reg_d     = s_reg_q;
        s_rw_d      = s_rw_q;
        s_sda_low_d = s_sda_low_q;
        scl_prev_d  = scl_line;
        sda_prev_d  = sda_line;

        if (stop_c) begin
            s_state_d   = S_IDLE;
            s_sda_low_d = 1'b0;
        end else if (start_c) begin
            s_state_d   = S_ADDR;
            s_cnt_d     = 4'd0;
            s_sda_low_d = 1'b0;
        end else if (scl_rise) begin
            case (s_state_q)
                S_ADDR: begin
                    s_shift_d = {s_shift_q[6:0], sda_line};
                    s_cnt_d   = s_cnt_q + 1'b1;
                end
                S_WR: begin
                    s_shift_d = {s_shift_q[6:0], sda_line};
                    s_cnt_d   = s_cnt_q + 1'b1;
                    if (s_cnt_q == 4'd7) s_reg_d = {s_shift_q[6:0], sda_line};
                end
                S_RD:    s_cnt_d = s_cnt_q + 1'b1;
                default: ;
            endcase
        end else if (scl_fall) begin
            // Every change the slave makes to SDA happens just after SCL falls.
            case (s_state_q)
                S_ADDR: begin
                    if (s_cnt_q == 4'd8) begin
                        if (s_shift_q[7:1] == SLAVE_ADDR) begin
                            s_state_d   = S_ADDR_ACK;
                            s_sda_low_d = 1'b1;
                            s_rw_d      = s_shift_q[0];
                        end else begin
                            s_state_d = S_IDLE;
                        end
                    end
                end
                S_ADDR_ACK: begin
                    s_cnt_d = 4'd0;
                    if (s_rw_q) begin
                        s_state_d   = S_RD;
                        s_shift_d   = s_reg_q;
                        s_sda_low_d = ~s_reg_q[7];
                    end else begin
                        s_state_d   = S_WR;
                        s_sda_low_d = 1'b0;
                    end
                end
                S_WR: begin
                    if (s_cnt_q == 4'd8) begin
                        s_state_d   = S_WR_ACK;
                        s_sda_low_d = 1'b1;
                    end
                end
                S_RD: begin
                    if (s_cnt_q == 4'd8) begin
                        s_state_d   = S_IDLE;
                        s_sda_low_d = 1'b0;
                    end else begin
                        s_sda_low_d = ~s_shift_q[6];
                        s_shift_d   = {s_shift_q[6:0], 1'b0};
                    end
                end
                S_WR_ACK: begin
                    s_state_d   = S_IDLE;
                    s_sda_low_d = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_state_q   <= S_IDLE;
            s_cnt_q     <= 4'd0;
            s_shift_q   <= 8'h00;
            s_reg_q     <= 8'h00;
            s_rw_q      <= 1'b0;
            s_sda_low_q <= 1'b0;
            scl_prev_q  <= 1'b1;
            sda_prev_q  <= 1'b1;
        end else begin
            s_state_q   <= s_state_d;
            s_cnt_q     <= s_cnt_d;
            s_shift_q   <= s_shift_d;
            s_reg_q     <= s_reg_d;
            s_rw_q      <= s_rw_d;
            s_sda_low_q <= s_sda_low_d;
            scl_prev_q  <= scl_prev_d;
            sda_prev_q  <= sda_prev_d;
        end
    end

endmodule

// File: tb/tb_i2c_loopback_top.sv
// Testbench for i2c_loopback_top: a bus monitor turns line activity into
// tokens (START, STOP, byte+ack); each scenario pushes the tokens it expects
// and compares them against what the monitor collected.
module tb_i2c_loopback_top;

    localparam int TOK_START = 1000;
    localparam int TOK_STOP  = 2000;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] addr;
    logic [7:0] data_in;
    logic       enable;
    logic       rw;
    logic [7:0] data_out;
    logic       ready;
    wire        sda_w;
    wire        scl_w;

    pullup (sda_w);
    pullup (scl_w);

    always #5 clk = ~clk;

    i2c_loopback_top #(.SLAVE_ADDR(7'h2A), .SCL_HALF(2)) dut (
        .clk(clk), .rst(rst), .addr(addr), .data_in(data_in), .enable(enable),
        .rw(rw), .data_out(data_out), .ready(ready), .i2c_sda(sda_w), .i2c_scl(scl_w)
    );

    logic sda_v, scl_v;
    assign sda_v = (sda_w !== 1'b0);
    assign scl_v = (scl_w !== 1'b0);

    int n_tests = 0;
    int n_fail  = 0;
    int exp_q[$];
    int obs_q[$];

    function automatic int tok(input logic [7:0] b, input logic ack);
        return int'({b, ack});
    endfunction

    // Bus monitor
    logic       m_sda_p = 1'b1;
    logic       m_scl_p = 1'b1;
    int         m_nbits = 0;
    logic [8:0] m_sh    = '0;

    always @(negedge clk) begin
        if (!rst) begin
            m_nbits <= 0;
        end else if (scl_v && m_scl_p && m_sda_p && !sda_v) begin
            obs_q.push_back(TOK_START);
            m_nbits <= 0;
        end else if (scl_v && m_scl_p && !m_sda_p && sda_v) begin
            obs_q.push_back(TOK_STOP);
            m_nbits <= 0;
        end else if (scl_v && !m_scl_p) begin
            m_sh <= {m_sh[7:0], sda_v};
            if (m_nbits == 8) begin
                obs_q.push_back(int'({m_sh[7:0], sda_v}));
                m_nbits <= 0;
            end else begin
                m_nbits <= m_nbits + 1;
            end
        end
        m_sda_p <= sda_v;
        m_scl_p <= scl_v;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_ready(input logic lvl, output int cyc);
        cyc = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (ready === lvl) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic push_txn(input logic [7:0] a_byte, input logic a_ack,
                            input logic has_data, input logic [7:0] d_byte, input logic d_ack);
        exp_q.push_back(TOK_START);
        exp_q.push_back(tok(a_byte, a_ack));
        if (has_data) exp_q.push_back(tok(d_byte, d_ack));
        exp_q.push_back(TOK_STOP);
    endtask

    task automatic run_txn(input logic [6:0] a, input logic [7:0] d, input logic r, output int cyc);
        int c;
        @(negedge clk);
        addr = a; data_in = d; rw = r; enable = 1'b1;
        wait_ready(1'b0, c);
        enable = 1'b0;
        if (c < 0) begin
            cyc = -1;
        end else begin
            wait_ready(1'b1, cyc);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; enable = 1'b0; addr = 7'h00; data_in = 8'h00; rw = 1'b0;
        repeat (5) tick();
        n_tests++;
        if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_held got=%b exp=0", ready); end
        rst = 1'b1;
        tick();
        n_tests++;
        if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", ready); end
        n_tests++;
        if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data_out got=%h exp=00", data_out); end
        n_tests++;
        if ({sda_v, scl_v} !== 2'b11) begin n_fail++; $display("FAIL reset_lines got=%b exp=11", {sda_v, scl_v}); end
        obs_q.delete();
    endtask

    task automatic test_write_ack();
        int cyc;
        push_txn(8'h54, 1'b0, 1'b1, 8'hAA, 1'b0);
        run_txn(7'h2A, 8'hAA, 1'b0, cyc);
        n_tests++;
        if (cyc < 0) begin n_fail++; $display("FAIL write_ack_timeout got=timeout exp=ready"); end
        n_tests++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL write_ack_tokens got=%0d exp=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            int e = exp_q.pop_front();
            int o = obs_q.pop_front();
            n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL write_ack_token got=%0h exp=%0h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
        n_tests++;
        if (data_out !== 8'h00) begin n_fail++; $display("FAIL write_ack_data_out got=%h exp=00", data_out); end
    endtask

    task automatic test_write_nack();
        int cyc;
        push_txn(8'hFE, 1'b1, 1'b0, 8'h00, 1'b0);
        run_txn(7'h7F, 8'hCC, 1'b0, cyc);
        n_tests++;
        if (cyc < 0) begin n_fail++; $display("FAIL nack_timeout got=timeout exp=ready"); end
        n_tests++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL nack_tokens got=%0d exp=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            int e = exp_q.pop_front();
            int o = obs_q.pop_front();
            n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL nack_token got=%0h exp=%0h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
        n_tests++;
        if (data_out !== 8'h00) begin n_fail++; $display("FAIL nack_data_out got=%h exp=00", data_out); end
    endtask

    task automatic test_read();
        int cyc;
        push_txn(8'h55, 1'b0, 1'b1, 8'hAA, 1'b1);
        run_txn(7'h2A, 8'h00, 1'b1, cyc);
        n_tests++;
        if (cyc < 0) begin n_fail++; $display("FAIL read_timeout got=timeout exp=ready"); end
        n_tests++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL read_tokens got=%0d exp=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            int e = exp_q.pop_front();
            int o = obs_q.pop_front();
            n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL read_token got=%0h exp=%0h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
        n_tests++;
        if (data_out !== 8'hAA) begin n_fail++; $display("FAIL read_data_out got=%h exp=AA", data_out); end
    endtask

    task automatic test_reset_mid();
        int c;
        int cyc;
        @(negedge clk);
        addr = 7'h2A; data_in = 8'h33; rw = 1'b0; enable = 1'b1;
        wait_ready(1'b0, c);
        enable = 1'b0;
        repeat (8) tick();
        for (int i = 0; i < 8 && scl_v; i++) tick();
        n_tests++;
        if (scl_v !== 1'b0) begin n_fail++; $display("FAIL mid_scl_low got=%b exp=0", scl_v); end
        rst = 1'b0;
        #1;
        n_tests++;
        if ({sda_v, scl_v} !== 2'b11) begin n_fail++; $display("FAIL mid_lines_released got=%b exp=11", {sda_v, scl_v}); end
        n_tests++;
        if (data_out !== 8'h00) begin n_fail++; $display("FAIL mid_data_out got=%h exp=00", data_out); end
        repeat (3) tick();
        n_tests++;
        if (ready !== 1'b0) begin n_fail++; $display("FAIL mid_ready_held got=%b exp=0", ready); end
        rst = 1'b1;
        tick();
        n_tests++;
        if (ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready_after got=%b exp=1", ready); end
        exp_q.delete(); obs_q.delete();
        push_txn(8'h55, 1'b0, 1'b1, 8'h00, 1'b1);
        run_txn(7'h2A, 8'h00, 1'b1, cyc);
        n_tests++;
        if (cyc < 0) begin n_fail++; $display("FAIL mid_read_timeout got=timeout exp=ready"); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            int e = exp_q.pop_front();
            int o = obs_q.pop_front();
            n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL mid_read_token got=%0h exp=%0h", o, e); end
        end
        n_tests++;
        if (exp_q.size() != 0 || obs_q.size() != 0) begin
            n_fail++; $display("FAIL mid_read_leftover got=%0d/%0d exp=0/0", exp_q.size(), obs_q.size());
        end
        exp_q.delete(); obs_q.delete();
        n_tests++;
        if (data_out !== 8'h00) begin n_fail++; $display("FAIL mid_reg_cleared got=%h exp=00", data_out); end
    endtask

    task automatic test_back_to_back();
        int c;
        push_txn(8'h54, 1'b0, 1'b1, 8'hAA, 1'b0);
        push_txn(8'h54, 1'b0, 1'b1, 8'hAA, 1'b0);
        @(negedge clk);
        addr = 7'h2A; data_in = 8'hAA; rw = 1'b0; enable = 1'b1;
        wait_ready(1'b0, c);
        n_tests++;
        if (c < 0) begin n_fail++; $display("FAIL b2b_accept1 got=timeout exp=busy"); end
        // Toggle enable and disturb the inputs while busy; none of it may stick.
        repeat (3) tick();
        enable = 1'b0; data_in = 8'h11; addr = 7'h7F; rw = 1'b1;
        repeat (3) tick();
        enable = 1'b1; data_in = 8'hAA; addr = 7'h2A; rw = 1'b0;
        wait_ready(1'b1, c);
        n_tests++;
        if (c < 0) begin n_fail++; $display("FAIL b2b_done1 got=timeout exp=ready"); end
        tick();
        n_tests++;
        if (ready !== 1'b0) begin n_fail++; $display("FAIL b2b_restart got=%b exp=0", ready); end
        enable = 1'b0; data_in = 8'h11;
        wait_ready(1'b1, c);
        n_tests++;
        if (c < 0) begin n_fail++; $display("FAIL b2b_done2 got=timeout exp=ready"); end
        n_tests++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL b2b_tokens got=%0d exp=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            int e = exp_q.pop_front();
            int o = obs_q.pop_front();
            n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL b2b_token got=%0h exp=%0h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
        push_txn(8'h55, 1'b0, 1'b1, 8'hAA, 1'b1);
        run_txn(7'h2A, 8'h00, 1'b1, c);
        n_tests++;
        if (c < 0) begin n_fail++; $display("FAIL b2b_read_timeout got=timeout exp=ready"); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            int e = exp_q.pop_front();
            int o = obs_q.pop_front();
            n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL b2b_read_token got=%0h exp=%0h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
        n_tests++;
        if (data_out !== 8'hAA) begin n_fail++; $display("FAIL b2b_readback got=%h exp=AA", data_out); end
    endtask

    initial begin
        test_reset();
        test_write_ack();
        test_write_nack();
        test_read();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
